fetch_unit: RTL and testbench

- IF stage directly upstream of the branch unit.
- Owns the PC register and issues instruction-memory requests over a req/ack handshake.
- Drives the branch-unit LUT read key (pc) and consumes its prediction (take_branch, branch_predict).
- Applies redirect (jump_address) and flush/stall masks, and loads the IF/ID pipeline register, including the predicted-taken bit that the branch unit later sees as branch_taken.

---
 rtl/fetch_unit.sv | 157 +++++++++++++++
 tb/tb_fetch_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, runs the imem req/ack handshake and loads IF/ID.
// Holds one skid entry so an acked fetch is never lost under an IF/ID stall.
`ifndef NUM_PIPE_MASKS
`define NUM_PIPE_MASKS 4
`endif
`ifndef PIPE_REG_PC
`define PIPE_REG_PC 0
`endif
`ifndef PIPE_REG_IF_ID
`define PIPE_REG_IF_ID 1
`endif

module fetch_unit #(
    parameter int ADDR_WIDTH = 16,
    parameter int INST_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [`NUM_PIPE_MASKS-1:0] flush,
    input  logic [`NUM_PIPE_MASKS-1:0] stall,
    input  logic [ADDR_WIDTH-1:0]      jump_address,
    output logic [ADDR_WIDTH-1:0]      pc,
    input  logic                       take_branch,
    input  logic [ADDR_WIDTH-1:0]      branch_predict,
    output logic                       imem_req,
    output logic [ADDR_WIDTH-1:0]      imem_addr,
    input  logic                       imem_ack,
    input  logic [INST_WIDTH-1:0]      imem_rdata,
    output logic [ADDR_WIDTH-1:0]      if_id_pc,
    output logic [INST_WIDTH-1:0]      if_id_instruction,
    output logic                       if_id_branch_taken,
    output logic                       if_id_valid
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_DRAIN
    } state_t;

    typedef struct packed {
        logic                  valid;
        logic                  taken;
        logic [ADDR_WIDTH-1:0] pc;
        logic [INST_WIDTH-1:0] instr;
    } entry_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] redir_q, redir_d;
    entry_t                id_q, id_d;
    entry_t                skid_q, skid_d;

    logic pc_flush, id_flush, id_stall;
    logic req, ack, accept;
    logic unused_mask_bits;

    assign pc_flush = flush[`PIPE_REG_PC];
    assign id_flush = flush[`PIPE_REG_IF_ID];
    assign id_stall = stall[`PIPE_REG_IF_ID];
    assign unused_mask_bits = ^{flush, stall};

    // PC only changes once the outstanding request is retired, so it is
    // also the stale address while draining.
    assign req = reset && ((state_q != S_FETCH)
               || (!stall[`PIPE_REG_PC] && !skid_q.valid));
    assign ack = imem_ack && req;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        redir_d = redir_q;
        accept  = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                if (pc_flush) begin
                    pc_d = jump_address;
                end else if (req) begin
                    if (ack) accept = 1'b1;
                    else     state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (pc_flush) begin
                    if (ack) begin
                        pc_d    = jump_address;
                        state_d = S_FETCH;
                    end else begin
                        redir_d = jump_address;
                        state_d = S_DRAIN;
                    end
                end else if (ack) begin
                    accept = 1'b1;
                end
            end
            S_DRAIN: begin
                if (pc_flush) redir_d = jump_address;
                if (ack) begin
                    pc_d    = pc_flush ? jump_address : redir_q;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
        if (accept) begin
            pc_d    = take_branch ? branch_predict
                                  : pc_q + ADDR_WIDTH'(1);
            state_d = S_FETCH;
        end
    end

    always_comb begin
        id_d   = id_q;
        skid_d = skid_q;
        if (id_flush) begin
            id_d   = '0;
            skid_d = '0;
        end else if (!id_stall) begin
            if (skid_q.valid) begin
                id_d   = skid_q;
                skid_d = '0;
            end else if (accept) begin
                id_d = '{1'b1, take_branch, pc_q, imem_rdata};
            end else begin
                id_d = '0;
            end
        end else if (accept) begin
            skid_d = '{1'b1, take_branch, pc_q, imem_rdata};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            redir_q <= '0;
            id_q    <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            redir_q <= redir_d;
            id_q    <= id_d;
            skid_q  <= skid_d;
        end
    end

    assign pc                 = pc_q;
    assign imem_req           = req;
    assign imem_addr          = pc_q;
    assign if_id_pc           = id_q.pc;
    assign if_id_instruction  = id_q.instr;
    assign if_id_branch_taken = id_q.taken;
    assign if_id_valid        = id_q.valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, prediction, redirect,
// skid under stall, PC wrap and reset during an outstanding request.
`ifndef NUM_PIPE_MASKS
`define NUM_PIPE_MASKS 4
`endif
`ifndef PIPE_REG_PC
`define PIPE_REG_PC 0
`endif
`ifndef PIPE_REG_IF_ID
`define PIPE_REG_IF_ID 1
`endif

module tb_fetch_unit;

    logic                       clk;
    logic                       reset;
    logic [`NUM_PIPE_MASKS-1:0] flush;
    logic [`NUM_PIPE_MASKS-1:0] stall;
    logic [15:0]                jump_address;
    logic [15:0]                pc;
    logic                       take_branch;
    logic [15:0]                branch_predict;
    logic                       imem_req;
    logic [15:0]                imem_addr;
    logic                       imem_ack;
    logic [31:0]                imem_rdata;
    logic [15:0]                if_id_pc;
    logic [31:0]                if_id_instruction;
    logic                       if_id_branch_taken;
    logic                       if_id_valid;

    logic        ack_en;
    logic        lut_en;
    logic [15:0] lut_pc;
    int checks;
    int failures;

    fetch_unit #(.ADDR_WIDTH(16), .INST_WIDTH(32), .RESET_PC(16'h0000)) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .stall(stall),
        .jump_address(jump_address),
        .pc(pc),
        .take_branch(take_branch),
        .branch_predict(branch_predict),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .if_id_pc(if_id_pc),
        .if_id_instruction(if_id_instruction),
        .if_id_branch_taken(if_id_branch_taken),
        .if_id_valid(if_id_valid)
    );

    always #5 clk = ~clk;

    // Zero-wait memory and LUT models driven off the DUT's request.
    always_comb begin
        imem_ack    = ack_en;
        imem_rdata  = (imem_addr == 16'h0007) ? 32'h0000_00AB
                                              : 32'h100 + 32'(imem_addr);
        take_branch = lut_en && (pc == lut_pc);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        flush = '0;
        stall = '0;
        ack_en = 1'b0;
        lut_en = 1'b0;
        jump_address = '0;
        step();
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset_seq();
        reset = 1'b0;
        #2;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", imem_req); end
        checks++; if (pc !== 16'h0) begin failures++; $display("FAIL rst_pc got=%h exp=0000", pc); end
        checks++; if ({if_id_valid, if_id_branch_taken, if_id_pc, if_id_instruction} !== 50'h0) begin failures++; $display("FAIL rst_ifid got v=%b t=%b pc=%h i=%h exp=0", if_id_valid, if_id_branch_taken, if_id_pc, if_id_instruction); end
        do_reset();
        ack_en = 1'b1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0) begin failures++; $display("FAIL seq_req got req=%b addr=%h exp=1/0000", imem_req, imem_addr); end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (if_id_pc !== 16'(i) || if_id_instruction !== 32'h100 + 32'(i) || if_id_valid !== 1'b1) begin failures++; $display("FAIL seq_%0d got pc=%h i=%h v=%b exp=%h/%h/1", i, if_id_pc, if_id_instruction, if_id_valid, 16'(i), 32'h100 + 32'(i)); end
        end
    endtask

    task automatic test_predict();
        do_reset();
        ack_en = 1'b1;
        lut_en = 1'b1;
        lut_pc = 16'h0002;
        branch_predict = 16'h0040;
        step();
        step();
        checks++; if (if_id_pc !== 16'h1 || if_id_branch_taken !== 1'b0) begin failures++; $display("FAIL pred_nt got pc=%h t=%b exp=0001/0", if_id_pc, if_id_branch_taken); end
        step();
        checks++; if (if_id_pc !== 16'h2 || if_id_branch_taken !== 1'b1) begin failures++; $display("FAIL pred_t got pc=%h t=%b exp=0002/1", if_id_pc, if_id_branch_taken); end
        checks++; if (imem_addr !== 16'h0040) begin failures++; $display("FAIL pred_addr got=%h exp=0040", imem_addr); end
        lut_en = 1'b0;
        step();
        checks++; if (if_id_pc !== 16'h0040 || if_id_instruction !== 32'h140) begin failures++; $display("FAIL pred_tgt got pc=%h i=%h exp=0040/00000140", if_id_pc, if_id_instruction); end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        ack_en = 1'b1;
        repeat (5) step();
        ack_en = 1'b0;
        step();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h5) begin failures++; $display("FAIL rdw_wait got req=%b addr=%h exp=1/0005", imem_req, imem_addr); end
        flush = '0;
        flush[`PIPE_REG_PC] = 1'b1;
        flush[`PIPE_REG_IF_ID] = 1'b1;
        jump_address = 16'h0020;
        step();
        flush = '0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h5 || if_id_valid !== 1'b0) begin failures++; $display("FAIL rdw_drain got req=%b addr=%h v=%b exp=1/0005/0", imem_req, imem_addr, if_id_valid); end
        step();
        checks++; if (imem_addr !== 16'h5) begin failures++; $display("FAIL rdw_hold got=%h exp=0005", imem_addr); end
        ack_en = 1'b1;
        step();
        checks++; if (if_id_valid !== 1'b0 || imem_addr !== 16'h0020) begin failures++; $display("FAIL rdw_discard got v=%b addr=%h exp=0/0020", if_id_valid, imem_addr); end
        step();
        checks++; if (if_id_pc !== 16'h0020 || if_id_instruction !== 32'h120 || if_id_valid !== 1'b1) begin failures++; $display("FAIL rdw_tgt got pc=%h i=%h v=%b exp=0020/00000120/1", if_id_pc, if_id_instruction, if_id_valid); end
    endtask

    task automatic test_skid();
        do_reset();
        ack_en = 1'b1;
        repeat (7) step();
        stall = '0;
        stall[`PIPE_REG_IF_ID] = 1'b1;
        step();
        checks++; if (if_id_pc !== 16'h6 || imem_req !== 1'b0) begin failures++; $display("FAIL skid_fill got pc=%h req=%b exp=0006/0", if_id_pc, imem_req); end
        step();
        checks++; if (if_id_pc !== 16'h6 || imem_req !== 1'b0) begin failures++; $display("FAIL skid_hold got pc=%h req=%b exp=0006/0", if_id_pc, imem_req); end
        stall = '0;
        step();
        checks++; if (if_id_pc !== 16'h7 || if_id_instruction !== 32'hAB || if_id_valid !== 1'b1) begin failures++; $display("FAIL skid_out got pc=%h i=%h v=%b exp=0007/000000ab/1", if_id_pc, if_id_instruction, if_id_valid); end
        checks++; if (imem_addr !== 16'h8) begin failures++; $display("FAIL skid_next got=%h exp=0008", imem_addr); end
        step();
        checks++; if (if_id_pc !== 16'h8 || if_id_instruction !== 32'h108) begin failures++; $display("FAIL skid_after got pc=%h i=%h exp=0008/00000108", if_id_pc, if_id_instruction); end
    endtask

    task automatic test_wrap_reset();
        do_reset();
        flush = '0;
        flush[`PIPE_REG_PC] = 1'b1;
        jump_address = 16'hFFFF;
        step();
        flush = '0;
        checks++; if (imem_addr !== 16'hFFFF) begin failures++; $display("FAIL wrap_jump got=%h exp=ffff", imem_addr); end
        ack_en = 1'b1;
        step();
        checks++; if (if_id_pc !== 16'hFFFF || if_id_instruction !== 32'h0001_00FF || imem_addr !== 16'h0) begin failures++; $display("FAIL wrap got pc=%h i=%h addr=%h exp=ffff/000100ff/0000", if_id_pc, if_id_instruction, imem_addr); end
        step();
        ack_en = 1'b0;
        step();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h1) begin failures++; $display("FAIL wr_wait got req=%b addr=%h exp=1/0001", imem_req, imem_addr); end
        reset = 1'b0;
        stall = '0;
        stall[`PIPE_REG_PC] = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0 || pc !== 16'h0) begin failures++; $display("FAIL wr_rst got req=%b pc=%h exp=0/0000", imem_req, pc); end
        checks++; if ({if_id_valid, if_id_branch_taken, if_id_pc, if_id_instruction} !== 50'h0) begin failures++; $display("FAIL wr_rst_ifid got v=%b pc=%h i=%h exp=0", if_id_valid, if_id_pc, if_id_instruction); end
        step();
        reset = 1'b1;
        ack_en = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL wr_stray_req got=%b exp=0", imem_req); end
        step();
        step();
        checks++; if (pc !== 16'h0 || if_id_valid !== 1'b0) begin failures++; $display("FAIL wr_stray got pc=%h v=%b exp=0000/0", pc, if_id_valid); end
        stall = '0;
        step();
        checks++; if (if_id_pc !== 16'h0 || if_id_instruction !== 32'h100 || if_id_valid !== 1'b1) begin failures++; $display("FAIL wr_resume got pc=%h i=%h v=%b exp=0000/00000100/1", if_id_pc, if_id_instruction, if_id_valid); end
    endtask

    initial begin
        clk = 1'b0;
        checks = 0;
        failures = 0;
        reset = 1'b0;
        flush = '0;
        stall = '0;
        jump_address = '0;
        branch_predict = '0;
        ack_en = 1'b0;
        lut_en = 1'b0;
        lut_pc = '0;
        test_reset_seq();
        test_predict();
        test_redirect_wait();
        test_skid();
        test_wrap_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
